bus_arbiter_ws: RTL and testbench
=================================

// Module: bus_arbiter_ws
// PURPOSE
//  Two-master / two-slave bus arbiter with wait-state handshake for the core's memory path.
//  Shares the ROM and RAM ports between the LSU (m0) and the IFU fetch (m1).
//  Slaves may stretch accesses with an ack; the block raises hold_flag so ctrl stalls the pipeline.
//  Adds starvation control for fetch, a per-access timeout and a decode-error response.
// PARAMETERS
//  FAIR_LIMIT  4   consecutive m0 grants while m1 waits before m1 is forced ahead (>=1)
//  TIMEOUT     15  max cycles s_req may stay unacked before forced error completion (>=1)
//  DEC_MSB     31  top bit of the 4-bit slave-select field addr[DEC_MSB:DEC_MSB-3]
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  mX_req         in   1   X=0 LSU, X=1 IFU; request, held until mX_ack
//  mX_we          in   1   1=write, 0=read
//  mX_addr        in   32  byte address
//  mX_sel         in   4   byte lane enables
//  mX_wdata       in   32  write data
//  mX_rdata       out  32  read data, valid only while mX_ack=1, else 0
//  mX_ack         out  1   one-cycle completion pulse
//  sY_req         out  1   Y=0 ROM (field 0x0), Y=1 RAM (field 0x1); held until sY_ack
//  sY_we/addr/sel/wdata  out  1/32/4/32  registered copies of the granted request
//  sY_rdata       in   32  slave read data, sampled when sY_ack=1
//  sY_ack         in   1   slave completion
//  err            out  1   pulses with mX_ack on decode error or timeout
//  hold_flag      out  1   to ctrl: some mX_req=1 that does not get mX_ack this cycle
// BEHAVIOUR
//  Reset: state IDLE; all sY_req, mX_ack and err are 0; latched request and counters cleared.
//  Reset: hold_flag=0. Any slave access in flight is abandoned.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: arbitration is fixed priority m0 > m1.
//   - Exception: when fair_cnt==FAIR_LIMIT and m1_req=1, m1 is granted.
//   - On grant, latch master id, we, addr, sel, wdata and the decoded slave.
//   - Then go to ACCESS, or to DONE with err if the slave-select field is not 0x0/0x1.
//  ACCESS:
//   - sY_req=1 for the latched slave, from the first cycle after grant.
//   - wait_cnt increments each cycle; on sY_ack, go to DONE and capture rdata.
//   - If wait_cnt reaches TIMEOUT without sY_ack, go to DONE with err=1 and rdata=0.
//   - sY_req drops in the same cycle as the DONE transition is registered.
//  DONE (1 cycle): mX_ack=1 to the latched master with captured rdata and err; then IDLE.
//  Latency: request at cycle N, zero-wait slave acks at N+1, mX_ack at N+2.
//  One idle bubble follows between back-to-back grants.
//  fair_cnt:
//   - +1 on each m0 grant made while m1_req=1, saturating at FAIR_LIMIT.
//   - Cleared on any m1 grant, or when m1_req=0 in IDLE.
//  Writes use the latched we/sel/wdata; mX_rdata=0 for writes.
//  Masters that change request fields or drop req before ack: the latched transaction still completes.
//   - The ack is still pulsed; no retry is attempted.
//  A slave ack arriving outside ACCESS, or for the unselected slave, is ignored.
//  hold_flag is combinational: (m0_req & ~m0_ack) | (m1_req & ~m1_ack).
//  Address and data paths are pass-through widths only; no arithmetic other than the counters.
//  Counters use $clog2(param+1) bits.
// STRUCTURE
//  Package bus_arb_pkg: state encoding, SLV_ROM=4'h0 / SLV_RAM=4'h1 decode constants, master id codes.
//  One sub-module, arb_wait_timer: wait_cnt with clear/enable and timeout flag.
//  The FSM, latches and fair_cnt stay in the top.
// TESTING
//  1. Single m0 read 0x1000_0004, s1 acks after 0 waits -> m0_ack at N+2, rdata=s1_rdata, err=0, s0_req never set.
//  2. m0_req and m1_req rise together, both slaves ack at once -> m0 served first, then m1.
//     hold_flag stays 1 for m1 until its ack.
//  3. m0_req held continuously with m1_req=1, FAIR_LIMIT=4 -> after 4 m0 grants, m1 granted.
//     fair_cnt then returns to 0.
//  4. m1 fetch to 0x0000_0100, s0 never acks, TIMEOUT=15 -> s0_req high 15 cycles.
//     Then m1_ack=1, err=1, rdata=0.
//  5. m0 write to 0x2000_0000 -> no sY_req, m0_ack with err=1 at N+1.
//  6. rst_n asserted mid-ACCESS -> all outputs 0 immediately; first post-reset request completes normally.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - state encoding, slave decode and master id constants for bus_arbiter_ws
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic [3:0] SLV_ROM = 4'h0;
  localparam logic [3:0] SLV_RAM = 4'h1;

  localparam logic MST_LSU = 1'b0;
  localparam logic MST_IFU = 1'b1;

  function automatic logic slv_valid(input logic [3:0] field);
    return (field == SLV_ROM) || (field == SLV_RAM);
  endfunction

endpackage

// File: rtl/bus_arbiter_ws_if.sv
// rtl/bus_arbiter_ws_if.sv - one request/ack bus channel shared by masters and slaves
interface bus_arbiter_ws_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - per-access wait counter with timeout flag
module arb_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Raised in the cycle whose increment would make the count reach TIMEOUT.
  assign timeout_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter_ws.sv
// rtl/bus_arbiter_ws.sv - two-master/two-slave arbiter with wait states, fetch fairness and timeout
module bus_arbiter_ws
  import bus_arb_pkg::*;
#(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 15,
  parameter int DEC_MSB    = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_ws_if.slave   m0,
  bus_arbiter_ws_if.slave   m1,
  bus_arbiter_ws_if.master  s0,
  bus_arbiter_ws_if.master  s1,
  output logic              err,
  output logic              hold_flag
);

  localparam int FW = $clog2(FAIR_LIMIT + 1);

  arb_state_e     state_q;
  logic           mst_q;
  logic           slv_q;
  logic           we_q;
  logic [31:0]    addr_q;
  logic [3:0]     sel_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q;
  logic [1:0]     s_req_q;
  logic [1:0]     m_ack_q;
  logic           err_q;
  logic [FW-1:0]  fair_q;

  logic           gnt_mst_d;
  logic           g_we_d;
  logic [31:0]    g_addr_d;
  logic [3:0]     g_sel_d;
  logic [31:0]    g_wdata_d;
  logic [3:0]     g_field_d;
  logic           s_ack_d;
  logic [31:0]    s_rdata_d;
  logic           timeout_d;

  // m1 wins when m0 is idle or when m0 has used up its consecutive-grant allowance.
  always_comb begin
    gnt_mst_d = (m1.req && (!m0.req || (fair_q == FW'(FAIR_LIMIT)))) ? MST_IFU : MST_LSU;
    g_we_d    = (gnt_mst_d == MST_IFU) ? m1.we    : m0.we;
    g_addr_d  = (gnt_mst_d == MST_IFU) ? m1.addr  : m0.addr;
    g_sel_d   = (gnt_mst_d == MST_IFU) ? m1.sel   : m0.sel;
    g_wdata_d = (gnt_mst_d == MST_IFU) ? m1.wdata : m0.wdata;
    g_field_d = g_addr_d[DEC_MSB -: 4];
  end

  assign s_ack_d   = slv_q ? s1.ack   : s0.ack;
  assign s_rdata_d = slv_q ? s1.rdata : s0.rdata;

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q != ST_ACCESS),
    .en_i      (state_q == ST_ACCESS),
    .timeout_o (timeout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mst_q   <= MST_LSU;
      slv_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      s_req_q <= '0;
      m_ack_q <= '0;
      err_q   <= 1'b0;
      fair_q  <= '0;
    end else begin
      m_ack_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdata_q <= '0;
          if (!m1.req) fair_q <= '0;
          if (m0.req || m1.req) begin
            mst_q   <= gnt_mst_d;
            slv_q   <= g_field_d[0];
            we_q    <= g_we_d;
            addr_q  <= g_addr_d;
            sel_q   <= g_sel_d;
            wdata_q <= g_wdata_d;
            if (gnt_mst_d == MST_IFU) begin
              fair_q <= '0;
            end else if (m1.req && (fair_q != FW'(FAIR_LIMIT))) begin
              fair_q <= fair_q + FW'(1);
            end
            if (slv_valid(g_field_d)) begin
              state_q               <= ST_ACCESS;
              s_req_q[g_field_d[0]] <= 1'b1;
            end else begin
              state_q            <= ST_DONE;
              m_ack_q[gnt_mst_d] <= 1'b1;
              err_q              <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (s_ack_d) begin
            state_q        <= ST_DONE;
            s_req_q        <= '0;
            m_ack_q[mst_q] <= 1'b1;
            rdata_q        <= we_q ? '0 : s_rdata_d;
          end else if (timeout_d) begin
            state_q        <= ST_DONE;
            s_req_q        <= '0;
            m_ack_q[mst_q] <= 1'b1;
            err_q          <= 1'b1;
            rdata_q        <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s0.req   = s_req_q[0];
  assign s0.we    = we_q;
  assign s0.addr  = addr_q;
  assign s0.sel   = sel_q;
  assign s0.wdata = wdata_q;
  assign s1.req   = s_req_q[1];
  assign s1.we    = we_q;
  assign s1.addr  = addr_q;
  assign s1.sel   = sel_q;
  assign s1.wdata = wdata_q;

  assign m0.ack   = m_ack_q[0];
  assign m1.ack   = m_ack_q[1];
  assign m0.rdata = m_ack_q[0] ? rdata_q : '0;
  assign m1.rdata = m_ack_q[1] ? rdata_q : '0;
  assign err      = err_q;

  assign hold_flag = (m0.req && !m_ack_q[0]) || (m1.req && !m_ack_q[1]);

endmodule

// File: tb/tb_bus_arbiter_ws.sv
// tb/tb_bus_arbiter_ws.sv - scoreboard bench for bus_arbiter_ws
module tb_bus_arbiter_ws;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_w;
  logic hold_w;

  bus_arbiter_ws_if m0_if ();
  bus_arbiter_ws_if m1_if ();
  bus_arbiter_ws_if s0_if ();
  bus_arbiter_ws_if s1_if ();

  bus_arbiter_ws #(.FAIR_LIMIT(4), .TIMEOUT(15), .DEC_MSB(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s0        (s0_if),
    .s1        (s1_if),
    .err       (err_w),
    .hold_flag (hold_w)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int s0_cnt = 0;
  int s1_cnt = 0;
  int m0_acks = 0;
  logic [1:0] resp_en = 2'b11;
  exp_t exp0[$];
  exp_t exp1[$];
  exp_t e_mon;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;

  function automatic logic [31:0] slv_rd(input logic y, input logic [31:0] a);
    return a ^ (y ? 32'hCAFE_0000 : 32'hBEEF_0000);
  endfunction

  assign s0_if.ack   = s0_if.req & resp_en[0];
  assign s1_if.ack   = s1_if.req & resp_en[1];
  assign s0_if.rdata = slv_rd(1'b0, s0_if.addr);
  assign s1_if.rdata = slv_rd(1'b1, s1_if.addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (s0_if.req) s0_cnt++;
    if (s1_if.req) s1_cnt++;
    if (s1_if.req && s1_if.ack) begin
      cap_wdata = s1_if.wdata;
      cap_sel   = s1_if.sel;
      cap_we    = s1_if.we;
    end
    if (m0_if.ack) begin
      m0_acks++;
      check("m0_pending", 32'(exp0.size() > 0), 32'd1);
      if (exp0.size() > 0) begin
        e_mon = exp0.pop_front();
        check("m0_rdata", m0_if.rdata, e_mon.rdata);
        check("m0_err", 32'(err_w), 32'(e_mon.err));
      end
    end
    if (m1_if.ack) begin
      check("m1_pending", 32'(exp1.size() > 0), 32'd1);
      if (exp1.size() > 0) begin
        e_mon = exp1.pop_front();
        check("m1_rdata", m1_if.rdata, e_mon.rdata);
        check("m1_err", 32'(err_w), 32'(e_mon.err));
      end
    end
  end

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel);
    if (m == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.sel = sel;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.sel = sel;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  task automatic xfer(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, output int lat);
    exp_t e;
    logic [3:0] f;
    int start;
    f = addr[31:28];
    e.err   = (f > 4'h1) ? 1'b1 : !resp_en[f[0]];
    e.rdata = (we || e.err) ? 32'h0 : slv_rd(f[0], addr);
    @(posedge clk); #1;
    if (m == 0) exp0.push_back(e); else exp1.push_back(e);
    drive(m, 1'b1, we, addr, wdata, sel);
    start = cyc;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_of(m)) begin
        lat = cyc - start;
        break;
      end
    end
    if (lat < 0) check("xfer_ack_bound", 32'(ack_of(m)), 32'd1);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    int l0, l1, hold_bad, c1a, c1b;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_s0_req", 32'(s0_if.req), 32'd0);
    check("rst_s1_req", 32'(s1_if.req), 32'd0);
    check("rst_acks", 32'({m0_if.ack, m1_if.ack}), 32'd0);
    check("rst_err", 32'(err_w), 32'd0);
    check("rst_hold", 32'(hold_w), 32'd0);
    rst_n = 1'b1;

    // single m0 read from RAM, zero-wait
    s0_cnt = 0; s1_cnt = 0;
    xfer(0, 1'b0, 32'h1000_0004, 32'h0, 4'hF, l0);
    check("t1_latency", 32'(l0), 32'd2);
    check("t1_s0_never", 32'(s0_cnt), 32'd0);
    check("t1_s1_cycles", 32'(s1_cnt), 32'd1);

    // simultaneous requests: m0 first, m1 after one bubble, hold_flag while m1 waits
    hold_bad = 0;
    fork
      xfer(0, 1'b0, 32'h1000_0020, 32'h0, 4'hF, l0);
      xfer(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, l1);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (m1_if.req && !m1_if.ack && !hold_w) hold_bad++;
        end
      end
    join
    check("t2_m0_latency", 32'(l0), 32'd2);
    check("t2_m1_latency", 32'(l1), 32'd5);
    check("t2_hold_m1", 32'(hold_bad), 32'd0);

    // fairness: m0 keeps requesting, m1 forced in after every 4 m0 grants
    m0_acks = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) xfer(0, 1'b0, 32'h1000_1000 + 32'(i * 4), 32'h0, 4'hF, l0);
      end
      begin
        xfer(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, l1);
        c1a = m0_acks;
        xfer(1, 1'b0, 32'h0000_0304, 32'h0, 4'hF, l1);
        c1b = m0_acks;
      end
    join
    check("t3_first_m1_after", 32'(c1a), 32'd4);
    check("t3_second_m1_after", 32'(c1b), 32'd8);

    // m1 fetch from ROM that never acks -> timeout
    resp_en[0] = 1'b0;
    s0_cnt = 0;
    xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, l1);
    check("t4_s0_req_cycles", 32'(s0_cnt), 32'd15);
    check("t4_latency", 32'(l1), 32'd16);
    resp_en[0] = 1'b1;

    // decode error write
    s0_cnt = 0; s1_cnt = 0;
    xfer(0, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, l0);
    check("t5_latency", 32'(l0), 32'd1);
    check("t5_no_sreq", 32'(s0_cnt + s1_cnt), 32'd0);

    // normal write to RAM, latched fields reach the slave
    xfer(1, 1'b1, 32'h1000_0010, 32'h1234_5678, 4'h3, l1);
    check("wr_latency", 32'(l1), 32'd2);
    check("wr_wdata", cap_wdata, 32'h1234_5678);
    check("wr_sel", 32'(cap_sel), 32'h3);
    check("wr_we", 32'(cap_we), 32'd1);

    // reset in the middle of an access
    resp_en[1] = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h1000_0040, 32'h0, 4'hF);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_s1_req", 32'(s1_if.req), 32'd0);
    check("t6_s1_addr", s1_if.addr, 32'h0);
    check("t6_m0_ack", 32'(m0_if.ack), 32'd0);
    check("t6_err", 32'(err_w), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("t6_hold", 32'(hold_w), 32'd0);
    resp_en[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h1000_0080, 32'h0, 4'hF, l0);
    check("t6_post_latency", 32'(l0), 32'd2);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp0.size() + exp1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
